// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DBITS_DEF = 16;
  localparam int unsigned ABITS_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RESP_I = 2'b01,
    ST_RESP_D = 2'b10
  } resp_state_e;

  // A byte address targets memory when every bit above the word-address field is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned abits);
    return (addr >> (abits + 1)) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_guard.sv
// Saturating count of contended data grants; forces fetch through once it hits STARVE.
module mem_port_arbiter_starve_guard #(
  parameter int unsigned STARVE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic ireq,
  input  logic ignt,
  input  logic dgnt,
  output logic force_fetch
);

  localparam int unsigned CW = (STARVE > 1) ? $clog2(STARVE + 1) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!ireq || ignt) begin
      cnt_q <= '0;
    end else if (dgnt && (cnt_q != CW'(STARVE))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign force_fetch = (cnt_q == CW'(STARVE));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and data requesters and
// steers the registered read data back to the owner of the previous cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DBITS  = DBITS_DEF,
  parameter int unsigned ABITS  = ABITS_DEF,
  parameter int unsigned STARVE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ireq,
  input  logic [DBITS-1:0] iaddr,
  output logic             ignt,
  output logic             ivalid,
  output logic [DBITS-1:0] idout,
  input  logic             dreq,
  input  logic             dwe,
  input  logic [DBITS-1:0] daddr,
  input  logic [DBITS-1:0] ddin,
  output logic             dgnt,
  output logic             dvalid,
  output logic [DBITS-1:0] ddout,
  output logic [ABITS-1:0] maddr,
  output logic [DBITS-1:0] mdin,
  output logic             mwe,
  input  logic [DBITS-1:0] mdout
);

  resp_state_e      state_q, state_d;
  logic [ABITS-1:0] maddr_q;
  logic [DBITS-1:0] idout_q, ddout_q;
  logic             d_mem, d_io, force_fetch;
  logic             iaddr_unused;

  assign d_mem        = dreq && addr_in_range(32'(daddr), ABITS);
  assign d_io         = dreq && !addr_in_range(32'(daddr), ABITS);
  assign mdin         = ddin;
  assign iaddr_unused = ^{iaddr[DBITS-1:ABITS+1], iaddr[0]};

  mem_port_arbiter_starve_guard #(
    .STARVE(STARVE)
  ) u_starve_guard (
    .clk        (clk),
    .rst        (rst),
    .ireq       (ireq),
    .ignt       (ignt),
    .dgnt       (dgnt),
    .force_fetch(force_fetch)
  );

  // Grant selection, port steering and response tracking.
  always_comb begin
    ignt    = 1'b0;
    dgnt    = 1'b0;
    mwe     = 1'b0;
    maddr   = maddr_q;
    state_d = ST_IDLE;
    ivalid  = 1'b0;
    dvalid  = 1'b0;
    idout   = idout_q;
    ddout   = ddout_q;

    if (!rst) begin
      if (d_io) begin
        // I/O accesses never touch the port, so fetch can share the cycle.
        dgnt = 1'b1;
        ignt = ireq;
      end else if (d_mem && !(ireq && force_fetch)) begin
        dgnt = 1'b1;
      end else begin
        ignt = ireq;
      end
    end

    if (ignt) begin
      maddr   = iaddr[ABITS:1];
      state_d = ST_RESP_I;
    end else if (dgnt && d_mem) begin
      maddr = daddr[ABITS:1];
      mwe   = dwe;
      if (!dwe) begin
        state_d = ST_RESP_D;
      end
    end

    case (state_q)
      ST_RESP_I: begin
        ivalid = 1'b1;
        idout  = mdout;
      end
      ST_RESP_D: begin
        dvalid = 1'b1;
        ddout  = mdout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      maddr_q <= '0;
      idout_q <= '0;
      ddout_q <= '0;
    end else begin
      state_q <= state_d;
      maddr_q <= maddr;
      idout_q <= idout;
      ddout_q <= ddout;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned STARVE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0;
  logic [15:0] iaddr = '0, daddr = '0, ddin = '0;
  logic        ignt, ivalid, dgnt, dvalid, mwe;
  logic [15:0] idout, ddout, mdin, mdout;
  logic [11:0] maddr;

  logic [15:0] mem [4096];

  mem_port_arbiter #(.DBITS(16), .ABITS(12), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .ireq(ireq), .iaddr(iaddr), .ignt(ignt), .ivalid(ivalid), .idout(idout),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .ddin(ddin),
    .dgnt(dgnt), .dvalid(dvalid), .ddout(ddout),
    .maddr(maddr), .mdin(mdin), .mwe(mwe), .mdout(mdout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int i);
    return 16'((i * 40503 + 4660) & 16'hFFFF);
  endfunction

  // Synchronous-read memory; reloads a known pattern while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
    end else if (mwe) begin
      mem[maddr] <= mdin;
    end
    mdout <= mem[maddr];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state: shadow memory, pending response, last outputs.
  logic [15:0] shadow [4096];
  int          m_starve;
  int          m_resp;            // 0 none, 1 fetch, 2 data
  logic [15:0] m_rdata, m_idout, m_ddout;
  logic [11:0] m_maddr;
  logic        e_ignt, e_dgnt;
  logic        o_ignt, o_dgnt, o_ivalid, o_dvalid, o_mwe;
  logic [15:0] o_idout, o_ddout;
  logic [11:0] o_maddr;

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) shadow[i] = init_word(i);
    m_starve = 0; m_resp = 0; m_rdata = '0;
    m_idout = '0; m_ddout = '0; m_maddr = '0;
  endtask

  // One clock cycle: predict, sample mid-cycle, then advance the model past the edge.
  task automatic step();
    int          owner;
    logic        in_rng, e_mwe;
    logic [11:0] e_maddr;
    #1;
    in_rng = (daddr >> 13) == 16'd0;
    owner  = 0;
    e_ignt = 1'b0;
    e_dgnt = dreq;
    if (dreq && in_rng && !(ireq && m_starve == STARVE)) owner = 2;
    else if (ireq) owner = 1;
    if (owner == 1) e_ignt = 1'b1;
    if (dreq && in_rng && owner != 2) e_dgnt = 1'b0;
    e_maddr = (owner == 1) ? iaddr[12:1] : (owner == 2) ? daddr[12:1] : m_maddr;
    e_mwe   = (owner == 2) && dwe;

    o_ignt = ignt; o_dgnt = dgnt; o_mwe = mwe; o_maddr = maddr;
    o_ivalid = ivalid; o_dvalid = dvalid; o_idout = idout; o_ddout = ddout;
    chk("ignt",   32'(o_ignt),   32'(e_ignt));
    chk("dgnt",   32'(o_dgnt),   32'(e_dgnt));
    chk("mwe",    32'(o_mwe),    32'(e_mwe));
    chk("maddr",  32'(o_maddr),  32'(e_maddr));
    chk("ivalid", 32'(o_ivalid), 32'(m_resp == 1));
    chk("dvalid", 32'(o_dvalid), 32'(m_resp == 2));
    chk("idout",  32'(o_idout),  32'((m_resp == 1) ? m_rdata : m_idout));
    chk("ddout",  32'(o_ddout),  32'((m_resp == 2) ? m_rdata : m_ddout));

    @(posedge clk);
    m_maddr = e_maddr;
    if (m_resp == 1) m_idout = m_rdata;
    if (m_resp == 2) m_ddout = m_rdata;
    m_resp = 0;
    if (owner == 1) begin
      m_resp = 1; m_rdata = shadow[iaddr[12:1]];
    end else if (owner == 2) begin
      if (dwe) shadow[daddr[12:1]] = ddin;
      else begin m_resp = 2; m_rdata = shadow[daddr[12:1]]; end
    end
    if (!ireq || e_ignt) m_starve = 0;
    else if (e_dgnt && m_starve < STARVE) m_starve++;
    @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ignt"},   32'(ignt),   32'd0);
    chk({tag, "_dgnt"},   32'(dgnt),   32'd0);
    chk({tag, "_mwe"},    32'(mwe),    32'd0);
    chk({tag, "_ivalid"}, 32'(ivalid), 32'd0);
    chk({tag, "_dvalid"}, 32'(dvalid), 32'd0);
    chk({tag, "_idout"},  32'(idout),  32'd0);
    chk({tag, "_ddout"},  32'(ddout),  32'd0);
    chk({tag, "_maddr"},  32'(maddr),  32'd0);
  endtask

  function automatic logic [15:0] rand_mem_addr();
    if ($urandom_range(0, 3) == 0) return 16'($urandom_range(0, 16'h1FFF));
    return 16'($urandom_range(0, 31) * 2);
  endfunction

  initial begin
    model_reset();
    // Requests during reset must be ignored and must not write memory.
    ireq = 1'b1; iaddr = 16'h0100;
    dreq = 1'b1; dwe = 1'b1; daddr = 16'h0030; ddin = 16'hDEAD;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_values("rst");
    @(negedge clk);

    // First cycle out of reset: read the address the reset-time write targeted.
    rst = 1'b0; ireq = 1'b0; dwe = 1'b0;
    step();
    chk("first_dgnt", 32'(o_dgnt), 32'd1);
    dreq = 1'b0;
    step();
    chk("first_ddout", 32'(o_ddout), 32'(init_word(16'h18)));

    // Fetch alone, after planting its word through the data port.
    dreq = 1'b1; dwe = 1'b1; daddr = 16'h0200; ddin = 16'h2C81;
    step();
    dreq = 1'b0; ireq = 1'b1; iaddr = 16'h0200;
    step();
    chk("fetch_ignt", 32'(o_ignt), 32'd1);
    chk("fetch_maddr", 32'(o_maddr), 32'h100);
    ireq = 1'b0;
    step();
    chk("fetch_ivalid", 32'(o_ivalid), 32'd1);
    chk("fetch_idout", 32'(o_idout), 32'h2C81);

    // Write then read back.
    dreq = 1'b1; dwe = 1'b1; daddr = 16'h0010; ddin = 16'hBEEF;
    step();
    chk("wr_mwe", 32'(o_mwe), 32'd1);
    chk("wr_maddr", 32'(o_maddr), 32'h008);
    dwe = 1'b0;
    step();
    chk("wr_no_dvalid", 32'(o_dvalid), 32'd0);
    dreq = 1'b0;
    step();
    chk("rd_ddout", 32'(o_ddout), 32'hBEEF);

    // Contention: three data grants, then fetch is forced through.
    ireq = 1'b1; iaddr = 16'h0300;
    dreq = 1'b1; dwe = 1'b0; daddr = 16'h0040;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k < 3) chk("cont_dgnt", 32'(o_dgnt), 32'd1);
      else chk("cont_ignt", 32'(o_ignt), 32'd1);
    end
    ireq = 1'b0;
    step();
    chk("cont_dgnt_after", 32'(o_dgnt), 32'd1);
    dreq = 1'b0;

    // Idle: nothing moves.
    repeat (5) step();
    chk("idle_maddr", 32'(o_maddr), 32'h020);

    // I/O bypass shares the cycle with a fetch.
    dreq = 1'b1; dwe = 1'b1; daddr = 16'hFFFC; ddin = 16'h1234;
    ireq = 1'b1; iaddr = 16'h0020;
    step();
    chk("io_dgnt", 32'(o_dgnt), 32'd1);
    chk("io_ignt", 32'(o_ignt), 32'd1);
    chk("io_mwe", 32'(o_mwe), 32'd0);
    dreq = 1'b0; ireq = 1'b0;
    step();
    chk("io_no_dvalid", 32'(o_dvalid), 32'd0);

    // Reset arriving while a fetch response is pending.
    ireq = 1'b1; iaddr = 16'h0200;
    step();
    rst = 1'b1; ireq = 1'b0;
    #1;
    chk_reset_values("rst_mid");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rst_mid_ivalid", 32'(o_ivalid), 32'd0);

    // Randomized traffic; requests are held until granted.
    for (int n = 0; n < 2000; n++) begin
      if (!ireq && $urandom_range(0, 2) == 0) begin
        ireq = 1'b1; iaddr = rand_mem_addr();
      end
      if (!dreq && $urandom_range(0, 1) == 0) begin
        dreq  = 1'b1;
        dwe   = 1'($urandom_range(0, 1));
        ddin  = 16'($urandom);
        daddr = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(16'h2000, 16'hFFFF))
                                            : rand_mem_addr();
      end
      step();
      if (e_ignt) ireq = 1'b0;
      if (e_dgnt) dreq = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
